// File: rtl/uart_msg_tx.sv
// Button-triggered UART transmitter that streams a stored multi-byte message.
// Synchroniser + debouncer -> trigger; message buffer with registered read; frame FSM.
module uart_msg_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MSG_DEPTH       = 16,
  localparam int AW             = $clog2(MSG_DEPTH)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Button,
  input  logic          i_Repeat,
  input  logic          i_Wr_En,
  input  logic [AW-1:0] i_Wr_Addr,
  input  logic [7:0]    i_Wr_Data,
  input  logic [AW:0]   i_Len,
  output logic          o_TxD,
  output logic          o_Busy,
  output logic          o_Done,
  output logic [AW-1:0] o_Byte_Idx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   MAX_LEN     = (AW+1)'(MSG_DEPTH);
  localparam logic [2:0]    DATA_LAST   = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST   = 3'(STOP_BITS - 1);
  localparam bit            PAR_EN      = (PARITY != 0);
  localparam bit            PAR_ODD     = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Button path: the debounced level only moves after DEBOUNCE_CYCLES disagreeing samples
  logic          sync_0_reg, sync_1_reg, db_level_reg, db_prev_reg;
  logic [DW-1:0] db_cnt_reg;
  logic          press;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_0_reg   <= 1'b0;
      sync_1_reg   <= 1'b0;
      db_level_reg <= 1'b0;
      db_prev_reg  <= 1'b0;
      db_cnt_reg   <= '0;
    end else begin
      sync_0_reg  <= i_Button;
      sync_1_reg  <= sync_0_reg;
      db_prev_reg <= db_level_reg;
      if (sync_1_reg == db_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        db_level_reg <= sync_1_reg;
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  assign press = db_level_reg & ~db_prev_reg;

  state_t                 state_reg, state_next;
  logic [BW-1:0]          baud_reg, baud_next;
  logic [2:0]             bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_reg, par_next;
  logic                   txd_reg, txd_next;
  logic                   done_reg, done_next;
  logic [AW-1:0]          idx_reg, idx_next;
  logic [AW:0]            len_reg, len_next;
  logic                   busy, bit_end, last_byte, load_byte;

  // Buffer: read address always points at the byte the next START will latch
  logic [DATA_BITS-1:0]   mem [MSG_DEPTH];
  logic [DATA_BITS-1:0]   rd_data_reg;
  logic [AW-1:0]          rd_idx;

  assign busy      = (state_reg != S_IDLE);
  assign bit_end   = (baud_reg == '0);
  assign last_byte = ({1'b0, idx_reg} == (len_reg - 1'b1));
  assign rd_idx    = (!busy || last_byte) ? '0 : idx_reg + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Wr_En && !busy) mem[i_Wr_Addr] <= i_Wr_Data[DATA_BITS-1:0];
    rd_data_reg <= mem[rd_idx];
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = (!busy || bit_end) ? BAUD_RELOAD : baud_reg - 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    txd_next   = txd_reg;
    done_next  = 1'b0;
    idx_next   = idx_reg;
    len_next   = len_reg;
    load_byte  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        txd_next = 1'b1;
        if (press && (i_Len != '0)) begin
          len_next  = (i_Len > MAX_LEN) ? MAX_LEN : i_Len;
          idx_next  = '0;
          load_byte = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          bit_next   = '0;
          txd_next   = shift_reg[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PAR_EN) begin
              state_next = S_PARITY;
              txd_next   = par_reg;
            end else begin
              state_next = S_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg >> 1;
            txd_next   = shift_reg[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          bit_next   = '0;
          txd_next   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_reg != STOP_LAST) begin
            bit_next = bit_reg + 1'b1;
          end else if (!last_byte) begin
            idx_next  = idx_reg + 1'b1;
            load_byte = 1'b1;
          end else if (i_Repeat) begin
            idx_next  = '0;
            load_byte = 1'b1;
          end else begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Entering START: latch the prefetched byte and drive the start bit
    if (load_byte) begin
      state_next = S_START;
      shift_next = rd_data_reg;
      par_next   = (^rd_data_reg) ^ PAR_ODD;
      txd_next   = 1'b0;
      baud_next  = BAUD_RELOAD;
      bit_next   = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg <= S_IDLE;
      baud_reg  <= BAUD_RELOAD;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      txd_reg   <= 1'b1;
      done_reg  <= 1'b0;
      idx_reg   <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      txd_reg   <= txd_next;
      done_reg  <= done_next;
      idx_reg   <= idx_next;
      len_reg   <= len_next;
    end
  end

  assign o_TxD      = txd_reg;
  assign o_Busy     = busy;
  assign o_Done     = done_reg;
  assign o_Byte_Idx = idx_reg;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx: expected serial bits queued per message, popped at mid-bit.
// Three instances share the buffer port; u_n (8N1) and u_e/u_o (even/odd parity).
module tb_uart_msg_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       button_p = 1'b0;
  logic       rep = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] len = '0;

  logic       txd_n, busy_n, done_n;
  logic       txd_e, busy_e, done_e;
  logic       txd_o, busy_o, done_o;
  logic [3:0] idx_n, idx_e, idx_o;

  int errors = 0;
  int checks = 0;

  logic q_n[$];
  logic q_e[$];
  logic q_o[$];
  int   idx_q[$];

  always #5 clk = ~clk;

  uart_msg_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                .DEBOUNCE_CYCLES(8), .MSG_DEPTH(16)) u_n (
    .i_Clk(clk), .i_Rst(rst), .i_Button(button), .i_Repeat(rep),
    .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .i_Len(len),
    .o_TxD(txd_n), .o_Busy(busy_n), .o_Done(done_n), .o_Byte_Idx(idx_n));

  uart_msg_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                .DEBOUNCE_CYCLES(8), .MSG_DEPTH(16)) u_e (
    .i_Clk(clk), .i_Rst(rst), .i_Button(button_p), .i_Repeat(rep),
    .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .i_Len(len),
    .o_TxD(txd_e), .o_Busy(busy_e), .o_Done(done_e), .o_Byte_Idx(idx_e));

  uart_msg_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                .DEBOUNCE_CYCLES(8), .MSG_DEPTH(16)) u_o (
    .i_Clk(clk), .i_Rst(rst), .i_Button(button_p), .i_Repeat(rep),
    .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .i_Len(len),
    .o_TxD(txd_o), .o_Busy(busy_o), .o_Done(done_o), .o_Byte_Idx(idx_o));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    $display("write addr=%0d data=%02h", a, d);
  endtask

  // Frame model: start, data LSB first, optional parity, one stop bit
  task automatic push_n(input logic [7:0] d);
    q_n.push_back(1'b0);
    for (int i = 0; i < 8; i++) q_n.push_back(d[i]);
    q_n.push_back(1'b1);
  endtask

  task automatic push_p(input logic [7:0] d);
    q_e.push_back(1'b0);
    q_o.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q_e.push_back(d[i]);
      q_o.push_back(d[i]);
    end
    q_e.push_back(^d);
    q_o.push_back(~(^d));
    q_e.push_back(1'b1);
    q_o.push_back(1'b1);
  endtask

  task automatic flush();
    q_n.delete(); q_e.delete(); q_o.delete(); idx_q.delete();
  endtask

  // Clean press; returns at the first negedge where the start bit is visible
  task automatic wait_start(input int sel, output bit ok);
    int lat;
    ok = 1'b0;
    if (sel == 0) button = 1'b1; else button_p = 1'b1;
    for (lat = 1; lat <= 40; lat++) begin
      tick();
      if ((sel == 0 && busy_n) || (sel != 0 && busy_e)) begin
        ok = 1'b1;
        break;
      end
    end
    button = 1'b0;
    button_p = 1'b0;
    chk("start_seen", ok, 1);
    if (ok) begin
      chk("press_latency", (lat >= 10 && lat <= 12), 1);
      chk("start_bit", (sel == 0) ? txd_n : txd_e, 0);
      if (sel != 0) chk("start_busy_o", busy_o, 1);
    end
  endtask

  // Cycle 0 is the first cycle of the start bit; end_n=-1 means n never finishes, -2 means n not monitored
  task automatic run_stream(input int cycles, input int end_n, input int end_p,
                            input int press_at, input int wr_at, input int drop_at);
    logic b;
    int   nbits;
    nbits = 0;
    for (int c = 0; c <= cycles; c++) begin
      if (c % 4 == 2) begin
        if (q_n.size() > 0) begin b = q_n.pop_front(); chk("txd_n", txd_n, b); nbits++; end
        if (q_e.size() > 0) begin b = q_e.pop_front(); chk("txd_even", txd_e, b); end
        if (q_o.size() > 0) begin b = q_o.pop_front(); chk("txd_odd", txd_o, b); end
        if (end_n == -1 || (end_n >= 0 && c < end_n)) begin
          chk("done_n_low", done_n, 0);
          chk("busy_n_high", busy_n, 1);
        end
      end
      if (c % 40 == 2 && idx_q.size() > 0) chk("byte_idx", idx_n, idx_q.pop_front());
      if (end_n >= 0 && c == end_n) begin
        chk("done_n_pulse", done_n, 1);
        chk("busy_n_fall", busy_n, 0);
      end
      if (end_n >= 0 && c == end_n + 1) chk("done_n_one_cycle", done_n, 0);
      if (c == end_p) begin
        chk("done_even", done_e, 1);
        chk("busy_even", busy_e, 0);
        chk("done_odd", done_o, 1);
        chk("busy_odd", busy_o, 0);
      end
      if (c == press_at) button = 1'b1;
      if (press_at >= 0 && c == press_at + 20) button = 1'b0;
      if (c == wr_at) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; end
      if (wr_at >= 0 && c == wr_at + 1) wr_en = 1'b0;
      if (c == drop_at) rep = 1'b0;
      if (c < cycles) tick();
    end
    chk("queue_drained", q_n.size() + q_e.size() + q_o.size() + idx_q.size(), 0);
    $display("stream cycles=%0d bits_n=%0d", cycles, nbits);
  endtask

  task automatic watch_idle(input int n, inout bit seen);
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | busy_n | ~txd_n;
    end
  endtask

  initial begin
    bit ok;
    bit seen;

    // Reset state
    tick();
    chk("rst_txd", txd_n, 1);
    chk("rst_busy", busy_n, 0);
    chk("rst_done", done_n, 0);
    chk("rst_idx", idx_n, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Bounce never accepted
    wr(4'd0, 8'h61);
    len = 5'd1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) button = ~button;
      tick();
      seen = seen | busy_n | ~txd_n;
    end
    button = 1'b0;
    watch_idle(40, seen);
    chk("bounce_no_tx", seen, 0);
    $display("bounce seen_activity=%0d", seen);

    // 8N1 single byte 0x61
    push_n(8'h61);
    idx_q.push_back(0);
    wait_start(0, ok);
    if (ok) run_stream(41, 40, -1, -1, -1, -1); else flush();

    // Even and odd parity, 44-cycle frames
    push_p(8'h61);
    wait_start(1, ok);
    if (ok) run_stream(45, -2, 44, -1, -1, -1); else flush();

    // Two bytes, second press and a write while busy
    wr(4'd0, 8'h48);
    wr(4'd1, 8'h69);
    len = 5'd2;
    push_n(8'h48); push_n(8'h69);
    idx_q.push_back(0); idx_q.push_back(1);
    wait_start(0, ok);
    if (ok) run_stream(81, 80, -1, 10, 50, -1); else flush();
    seen = 1'b0;
    watch_idle(30, seen);
    chk("no_queued_press", seen, 0);

    // Repeat; buffer must still hold 0x48 at addr 0
    rep = 1'b1;
    push_n(8'h48); push_n(8'h69); push_n(8'h48); push_n(8'h69);
    idx_q.push_back(0); idx_q.push_back(1); idx_q.push_back(0); idx_q.push_back(1);
    wait_start(0, ok);
    if (ok) run_stream(161, 160, -1, -1, -1, 130); else flush();
    rep = 1'b0;

    // Reset in the middle of data bit 1 (a 0 bit of 0x48)
    len = 5'd1;
    wait_start(0, ok);
    if (ok) begin
      repeat (8) tick();
      chk("pre_rst_txd", txd_n, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_txd", txd_n, 1);
      chk("mid_rst_busy", busy_n, 0);
      chk("mid_rst_done", done_n, 0);
      chk("mid_rst_idx", idx_n, 0);
      rst = 1'b0;
      $display("reset mid-frame applied");
    end
    seen = 1'b0;
    watch_idle(30, seen);
    chk("post_rst_idle", seen, 0);

    // Zero-length message ignored
    len = 5'd0;
    seen = 1'b0;
    button = 1'b1;
    watch_idle(20, seen);
    button = 1'b0;
    watch_idle(40, seen);
    chk("len0_no_tx", seen, 0);
    $display("len0 press seen_activity=%0d", seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Button-triggered, parametrised UART transmitter that sends a stored multi-byte message rather than one fixed byte. It integrates button synchronisation and debounce, a small message buffer loaded through a write port, and a frame serialiser. Data width, parity, stop bits, baud divider and buffer depth are configurable. It sits at the board top level between the push-button input and the TxD pin, and is the next-generation replacement for the single-byte debounce/timer/transmit chain.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit (≥2); 868 gives 115200 baud at 100 MHz
- DATA_BITS, 8: data bits per frame, 5..8
- PARITY, 0: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1: 1 or 2
- DEBOUNCE_CYCLES, 1000000: consecutive equal samples needed to accept a button level (≥2)
- MSG_DEPTH, 16: message buffer entries (≥2); AW = $clog2(MSG_DEPTH)
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous, active-high reset
- i_Button  in  1  raw asynchronous push button, active high
- i_Repeat  in  1  level; when high at end of message, message restarts
- i_Wr_En  in  1  buffer write strobe
- i_Wr_Addr  in  AW  buffer write address
- i_Wr_Data  in  8  buffer write data; only the low DATA_BITS bits are transmitted
- i_Len  in  AW+1  message length in bytes, 0..MSG_DEPTH
- o_TxD  out  1  serial output, idle high
- o_Busy  out  1  high from trigger until the final stop bit ends
- o_Done  out  1  one-cycle pulse when a message completes and no repeat follows
- o_Byte_Idx  out  AW  buffer index of the byte currently being sent

## Operation
- Button path: 2-FF synchroniser, then debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it. The counter clears on any sample equal to the current level. Press = 0→1 edge of the debounced level.
- Trigger: a press accepted in IDLE with i_Len != 0 starts a message at index 0. A press while busy, or with i_Len == 0, is dropped (not queued).
- i_Len is sampled at trigger and held for the message. Values above MSG_DEPTH are treated as MSG_DEPTH.
- Buffer: writes take effect when i_Wr_En is high and o_Busy is low. Writes while busy are discarded. Contents are not cleared by reset.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on trigger.
  - START → DATA after 1 bit time.
  - DATA shifts DATA_BITS bits, LSB first; → PARITY if PARITY != 0, else → STOP.
  - PARITY → STOP after 1 bit time.
  - STOP lasts STOP_BITS bit times. It then → START with the next index if more bytes remain. Otherwise → START at index 0 if i_Repeat is high, else → IDLE with o_Done.
- Parity bit: XOR of the DATA_BITS data bits, inverted for odd parity.
- Each byte is latched into the shift register on entry to START.
- Baud counter: reloads CLKS_PER_BIT−1 on every bit entry and decrements to 0. Each bit lasts exactly CLKS_PER_BIT cycles.
- Reset mid-frame: o_TxD returns to 1 on the next edge, the FSM goes to IDLE, and the debouncer clears to level 0. No partial stop bit or glitch beyond that edge.

## Timing
- Reset values: o_TxD=1, o_Busy=0, o_Done=0, o_Byte_Idx=0, FSM=IDLE, debounced level=0.
- Button latency: a clean press registers as a trigger 2 + DEBOUNCE_CYCLES cycles after i_Button rises (±1).
- Trigger cycle T: o_TxD=0 and o_Busy=1 from T+1.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- Bytes are sent back to back with no idle between frames; a repeat also inserts no gap.
- o_Busy falls in the same cycle o_Done pulses, which is T+1 + i_Len×F.
- o_Byte_Idx updates on entry to START.

## Test plan
- 8N1, CLKS_PER_BIT=4, DEBOUNCE_CYCLES=8; write 0x61 at addr 0, i_Len=1; clean press → o_TxD bits 0,1,0,0,0,0,1,1,0,1, each 4 cycles; o_Done pulses exactly 40 cycles after the start bit begins; o_Busy then 0.
- Same setup, PARITY=2 then PARITY=1 → parity bit after data is 1 (even) and 0 (odd); frame is 44 cycles.
- Bounce: i_Button toggles every 3 cycles for 30 cycles, then returns low → no start bit, o_Busy stays 0. A subsequent clean press → one message.
- Write 0x48,0x69 at addrs 0,1; i_Len=2; press → two contiguous frames, o_Byte_Idx 0 then 1, one o_Done after 80 cycles. A second press while busy is ignored. A write to addr 0 while busy leaves the buffer unchanged.
- i_Repeat=1, i_Len=2 → frames continue 0,1,0,1… with no o_Done. Drop i_Repeat during byte 1 → message ends after that byte, o_Done pulses.
- i_Rst asserted mid-data-bit → o_TxD=1 and o_Busy=0 on the next edge. i_Len=0 with a press → no activity.
